pipeline_capture_core: RTL and testbench
========================================

// Module: pipeline_capture_core
// PURPOSE
// Read-side companion of pipeline_propagation_core. Continuously records the
// delayed pipeline word stream into a circular history buffer. On a trigger it
// records POST_SAMPLES further words, then freezes. The frozen window is then
// read out oldest-first through a rd_en/rd_valid handshake.
// Used on the trigger-consolidation path for post-mortem readout of pipeline contents.
// PARAMETERS
// DATA_WIDTH    32  width of captured word
// DEPTH         8   history buffer entries; power of two, >=2
// POST_SAMPLES  3   words written after the trigger word; 0..DEPTH-1
// PORTS
// clk       in   1           single clock, all logic rising-edge
// arst      in   1           asynchronous reset, active-high
// ce        in   1           write enable / pipeline advance qualifier
// data_in   in   DATA_WIDTH  word from pipeline_propagation_core data_o
// arm       in   1           start capture (honoured in IDLE only)
// trig      in   1           trigger (honoured in ARMED only)
// rd_en     in   1           request next word (honoured in READOUT only)
// rd_data   out  DATA_WIDTH  readout word, registered
// rd_valid  out  1           rd_data valid, one-cycle pulse per rd_en
// rd_last   out  1           qualifies rd_valid: final word of the window
// state_o   out  2           0=IDLE 1=ARMED 2=POST 3=READOUT
// BEHAVIOUR
// - arst: state IDLE; wr_ptr, rd_ptr, fill, post_cnt cleared.
//   rd_data=0, rd_valid=0, rd_last=0. Buffer RAM contents are not cleared.
// - Write: in ARMED or POST, each cycle with ce=1 writes data_in at wr_ptr.
//   wr_ptr increments modulo DEPTH.
//   fill (width clog2(DEPTH+1)) increments and saturates at DEPTH.
//   Nothing is written when ce=0, or in IDLE or READOUT.
// - IDLE: arm=1 -> ARMED; wr_ptr and fill cleared on entry.
// - ARMED: trig=1 -> POST; post_cnt cleared.
//   A word written in the trigger cycle is a pre-trigger word.
//   trig is honoured regardless of ce.
//   If POST_SAMPLES=0, trig goes to READOUT directly.
// - POST: post_cnt increments on each ce write.
//   The write that makes post_cnt==POST_SAMPLES moves to READOUT next cycle.
// - READOUT entry: rd_ptr=(wr_ptr-fill) mod DEPTH; remaining=fill.
//   If fill=0, go to IDLE next cycle with no rd_valid.
// - READOUT: rd_en=1 with remaining>0 reads mem[rd_ptr].
//   rd_data/rd_valid appear the following cycle (latency 1).
//   rd_ptr wraps modulo DEPTH; remaining decrements.
//   Back-to-back rd_en every cycle is legal.
//   rd_last=1 with the word that brings remaining to 0.
//   The FSM returns to IDLE in the same cycle that word is presented.
// - rd_en outside READOUT or with remaining=0: ignored, rd_valid stays 0.
// - arm outside IDLE and trig outside ARMED: ignored, no side effect.
// - Simultaneous arm+trig in IDLE: only arm acts.
// - Simultaneous trig+ce in ARMED: the word is written, then POST.
// - rd_data holds its last value when rd_valid=0.
// - Reset mid-operation: immediate IDLE; any in-flight rd_valid is suppressed.
// TESTING (DATA_WIDTH=32, DEPTH=8, POST_SAMPLES=3; data_in increments by 1 each ce cycle)
// 1 arst held 10 cycles -> state_o=0, rd_valid=0, rd_last=0, rd_data=0; arm ignored while arst=1.
// 2 arm, ce=1, words 0..13; trig while 10 written -> state 3 after 13.
//   rd_en x8 back-to-back returns 6,7,...,13, one cycle after each rd_en.
//   rd_last only with 13, then state_o=0.
// 3 arm, words 0,1, trig with 2, then 3,4,5 -> readout 0..5 (6 words); rd_last with 5.
// 4 ce toggled 1010... during ARMED/POST -> only ce=1 words captured.
//   post_cnt ignores ce=0 cycles; readout is contiguous.
// 5 arst pulse after 3rd read word in scenario 2 -> rd_valid drops at once, state_o=0.
//   Re-arm and repeat scenario 2 -> identical 6..13 result.
// 6 trig in IDLE, arm in POST, rd_en in ARMED, 2 extra rd_en after rd_last -> all ignored.
//   No rd_valid, state sequence unchanged.

Source files
------------

// File: rtl/pipeline_capture_core.sv
// Circular capture of the delayed pipeline word stream. After a trigger it records
// POST_SAMPLES more words, freezes, and plays the window back oldest-first.
module pipeline_capture_core #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned POST_SAMPLES = 3
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [1:0]            state_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  localparam logic [AW-1:0] POST_MAX = AW'(POST_SAMPLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    POST    = 2'd2,
    READOUT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         post_cnt_q, post_cnt_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [FW-1:0]         remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic                  we;
  logic                  enter_ro;
  logic [AW-1:0]         post_cnt_inc;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign post_cnt_inc = post_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    post_cnt_d  = post_cnt_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    we          = 1'b0;
    enter_ro    = 1'b0;

    if ((state_q == ARMED || state_q == POST) && ce) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d  = ARMED;
          wr_ptr_d = '0;
          fill_d   = '0;
        end
      end
      ARMED: begin
        if (trig) begin
          post_cnt_d = '0;
          if (POST_SAMPLES == 0) enter_ro = 1'b1;
          else                   state_d  = POST;
        end
      end
      POST: begin
        if (ce) begin
          post_cnt_d = post_cnt_inc;
          if (post_cnt_inc == POST_MAX) enter_ro = 1'b1;
        end
      end
      READOUT: begin
        if (remaining_q == '0) begin
          state_d = IDLE;
        end else if (rd_en) begin
          rd_data_d   = mem[rd_ptr_q];
          rd_valid_d  = 1'b1;
          rd_last_d   = (remaining_q == FW'(1));
          rd_ptr_d    = rd_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == FW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Window start uses post-write pointer/fill so the final POST write is included.
    if (enter_ro) begin
      state_d     = READOUT;
      rd_ptr_d    = wr_ptr_d - fill_d[AW-1:0];
      remaining_d = fill_d;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_cnt_q  <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_cnt_q  <= post_cnt_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= data_in;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_pipeline_capture_core.sv
// Directed bench for pipeline_capture_core: a queue-based history/readout model
// checked every cycle, plus literal expectations on the read-back windows.
module tb_pipeline_capture_core;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned POSTS = 3;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          ce = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic [1:0]    state_o;

  pipeline_capture_core #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .POST_SAMPLES(POSTS)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .ce      (ce),
    .data_in (data_in),
    .arm     (arm),
    .trig    (trig),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_last (rd_last),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: 0=IDLE 1=ARMED 2=POST 3=READOUT; history as a sliding queue of the last DEPTH words.
  int            m_state = 0;
  int            m_post  = 0;
  logic [DW-1:0] hist[$];
  logic [DW-1:0] ro[$];
  logic [DW-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_last  = 1'b0;

  logic [DW-1:0] got[$];
  logic          gotl[$];

  task automatic push_word(input logic [DW-1:0] d);
    hist.push_back(d);
    if (hist.size() > DEPTH) void'(hist.pop_front());
  endtask

  always @(posedge clk) begin
    m_valid = 1'b0;
    m_last  = 1'b0;
    if (arst) begin
      m_state = 0; m_post = 0; m_data = '0;
      hist.delete(); ro.delete();
    end else begin
      case (m_state)
        0: if (arm) begin m_state = 1; hist.delete(); end
        1: begin
          if (ce) push_word(data_in);
          if (trig) begin
            m_post = 0;
            if (POSTS == 0) begin ro = hist; m_state = 3; end
            else m_state = 2;
          end
        end
        2: if (ce) begin
          push_word(data_in);
          m_post++;
          if (m_post == POSTS) begin ro = hist; m_state = 3; end
        end
        default: begin
          if (ro.size() == 0) m_state = 0;
          else if (rd_en) begin
            m_data  = ro.pop_front();
            m_valid = 1'b1;
            if (ro.size() == 0) begin m_last = 1'b1; m_state = 0; end
          end
        end
      endcase
    end
    #1;
    check("state_o", 32'(state_o), 32'(m_state));
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    check("rd_last", 32'(rd_last), 32'(m_last));
    check("rd_data", rd_data, m_data);
    if (rd_valid) begin
      got.push_back(rd_data);
      gotl.push_back(rd_last);
    end
  end

  int unsigned word = 0;

  task automatic cyc(input logic a, input logic t, input logic c, input logic r);
    arm = a; trig = t; ce = c; rd_en = r;
    data_in = c ? DW'(word) : 32'hDEADBEEF;
    @(negedge clk);
    if (c) word++;
  endtask

  task automatic check_words(input string name, input int unsigned first, input int unsigned n,
                             input logic last_on_final);
    check({name, "_count"}, 32'(got.size()), n);
    for (int unsigned i = 0; i < n && i < got.size(); i++) begin
      check({name, "_word"}, got[i], DW'(first + i));
      check({name, "_last"}, 32'(gotl[i]), 32'((i == n - 1) && last_on_final));
    end
  endtask

  task automatic run_s2(input int unsigned reads);
    word = 0;
    cyc(1, 0, 0, 0);
    for (int unsigned w = 0; w < 14; w++) cyc(0, (w == 10), 1, 0);
    check("s2_state_readout", 32'(state_o), 32'd3);
    got.delete(); gotl.delete();
    repeat (reads) cyc(0, 0, 0, 1);
  endtask

  initial begin
    // 1: reset held with arm asserted
    @(negedge clk);
    arm = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_last", 32'(rd_last), 32'd0);
    check("rst_data", rd_data, 32'd0);
    arm = 1'b0;
    arst = 1'b0;
    cyc(0, 0, 0, 0);

    // 2: trigger on word 10, window 6..13
    run_s2(8);
    cyc(0, 0, 0, 0);
    check_words("s2", 6, 8, 1'b1);
    check("s2_state_idle", 32'(state_o), 32'd0);

    // 3: partial fill, window 0..5
    word = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    check("s3_state_readout", 32'(state_o), 32'd3);
    got.delete(); gotl.delete();
    repeat (6) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check_words("s3", 0, 6, 1'b1);

    // 4: ce toggling; trigger with word 4, post words 5..7
    word = 0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 40 && state_o != 2'd3; i++) begin
      if (i % 2 == 0) cyc(0, (word == 4), 1, 0);
      else            cyc(0, 0, 0, 0);
    end
    check("s4_state_readout", 32'(state_o), 32'd3);
    got.delete(); gotl.delete();
    repeat (8) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check_words("s4", 0, 8, 1'b1);

    // 5: reset after the third read word, then a clean repeat
    run_s2(3);
    check("s5_valid_before", 32'(rd_valid), 32'd1);
    check_words("s5_pre", 6, 3, 1'b0);
    rd_en = 1'b0;
    arst = 1'b1;
    #1;
    check("s5_valid_drop", 32'(rd_valid), 32'd0);
    check("s5_state_idle", 32'(state_o), 32'd0);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    cyc(0, 0, 0, 0);
    run_s2(8);
    cyc(0, 0, 0, 0);
    check_words("s5", 6, 8, 1'b1);

    // 6: ignored controls; buffer ends up holding 1..8
    word = 0;
    got.delete(); gotl.delete();
    cyc(0, 1, 0, 1);
    check("s6_trig_idle", 32'(state_o), 32'd0);
    cyc(1, 1, 0, 0);
    check("s6_arm_trig", 32'(state_o), 32'd1);
    repeat (5) cyc(0, 0, 1, 1);
    check("s6_rd_armed", 32'(got.size()), 32'd0);
    cyc(0, 1, 1, 0);
    check("s6_post", 32'(state_o), 32'd2);
    repeat (3) cyc(1, 0, 1, 0);
    check("s6_state_readout", 32'(state_o), 32'd3);
    repeat (10) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check_words("s6", 1, 8, 1'b1);
    check("s6_state_idle", 32'(state_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
